// File: rtl/bram2ddr.sv
// bram2ddr: line-buffer write-back; packs 40 BRAM pixels into R/G/B planes and writes them as 3-beat DDR bursts.
// Optional macro BRAM2DDR_BANKSEL_EN adds rdsel, rotating reads over four line BRAMs (one per line).
//
// state | meaning
// IDLE  | waiting for a wrbt rising edge
// WAITL | waiting for a complete line in BRAM (pending)
// FETCH | reading 40 pixels, k=0..39; cycle k=40 collects the last pixel
// CMD   | one-cycle DDR write command
// DATA  | streaming R, G, B beats under wrready
// NEXT  | advancing group / line counters
module bram2ddr #(
    parameter int PIX_PER_GRP = 40,
    parameter int H_GRPS      = 48,
    parameter int V_LINES     = 1080,
    parameter int LINE_STRIDE = 144,
    parameter int BURST_LEN   = 3
) (
    input  logic                     ddrclk,
    input  logic                     reset,
    input  logic                     wrbt,
    input  logic                     line_ready,
    input  logic [23:0]              bram_dataout,
    output logic                     rden,
    output logic [10:0]              Bramaddr,
    output logic                     wr,
    output logic [24:0]              addr,
    output logic [6:0]               burst,
    output logic [PIX_PER_GRP*8-1:0] WrData,
    output logic                     wrvalid,
    input  logic                     wrready,
    output logic                     line_done,
    output logic                     frame_done,
`ifdef BRAM2DDR_BANKSEL_EN
    output logic [1:0]               rdsel,
`endif
    output logic                     busy
);

    localparam int DW = PIX_PER_GRP * 8;
    localparam int GW = $clog2(H_GRPS + 1);
    localparam int LW = $clog2(V_LINES + 1);
    localparam int KW = $clog2(PIX_PER_GRP + 1);

    typedef enum logic [2:0] {IDLE, WAITL, FETCH, CMD, DATA, NEXT} state_t;

    state_t          state, state_nxt;
    logic            wrbt_q;
    logic            pending;
    logic [GW-1:0]   grp;
    logic [LW-1:0]   line;
    logic [KW-1:0]   k;
    logic [1:0]      beat;
    logic            rd_q;
    logic [DW-1:0]   rbuf, gbuf, bbuf;
    logic            wrbt_edge, last_grp, last_line, last_beat, fetch_end;

    assign wrbt_edge = wrbt & ~wrbt_q;
    assign last_grp  = (grp == GW'(H_GRPS - 1));
    assign last_line = (line == LW'(V_LINES - 1));
    assign last_beat = (beat == 2'(BURST_LEN - 1));
    assign fetch_end = (k == KW'(PIX_PER_GRP));

    always_ff @(posedge ddrclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wrbt_edge) state_nxt = WAITL;
            WAITL:   if (pending) state_nxt = FETCH;
            FETCH:   if (fetch_end) state_nxt = CMD;
            CMD:     state_nxt = DATA;
            DATA:    if (wrready && last_beat) state_nxt = NEXT;
            NEXT: begin
                if (!last_grp)      state_nxt = FETCH;
                else if (last_line) state_nxt = IDLE;
                else                state_nxt = WAITL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rden       = (state == FETCH) && !fetch_end;
        Bramaddr   = '0;
        if (rden) Bramaddr = 11'(grp) * 11'(PIX_PER_GRP) + 11'(k);
        wr         = (state == CMD);
        addr       = '0;
        burst      = '0;
        if (wr) begin
            addr  = 25'(line) * 25'(LINE_STRIDE) + 25'(grp) * 25'(BURST_LEN);
            burst = 7'(BURST_LEN);
        end
        wrvalid    = (state == DATA);
        WrData     = '0;
        if (wrvalid) begin
            case (beat)
                2'd0:    WrData = rbuf;
                2'd1:    WrData = gbuf;
                default: WrData = bbuf;
            endcase
        end
        line_done  = (state == NEXT) && last_grp;
        frame_done = line_done && last_line;
        busy       = (state != IDLE);
    end

    always_ff @(posedge ddrclk or posedge reset) begin
        if (reset) begin
            wrbt_q  <= 1'b0;
            pending <= 1'b0;
            grp     <= '0;
            line    <= '0;
            k       <= '0;
            beat    <= '0;
            rd_q    <= 1'b0;
            rbuf    <= '0;
            gbuf    <= '0;
            bbuf    <= '0;
        end else begin
            wrbt_q <= wrbt;
            // a new line_ready wins over the clear so no line is lost
            if (line_ready)                       pending <= 1'b1;
            else if (state == WAITL && pending)   pending <= 1'b0;

            rd_q <= rden;
            if (rd_q) begin
                rbuf <= {rbuf[DW-9:0], bram_dataout[23:16]};
                gbuf <= {gbuf[DW-9:0], bram_dataout[15:8]};
                bbuf <= {bbuf[DW-9:0], bram_dataout[7:0]};
            end

            case (state)
                FETCH: k <= fetch_end ? '0 : k + KW'(1);
                DATA:  if (wrready) beat <= last_beat ? 2'd0 : beat + 2'd1;
                NEXT: begin
                    if (last_grp) begin
                        grp  <= '0;
                        line <= last_line ? '0 : line + LW'(1);
                    end else begin
                        grp <= grp + GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BRAM2DDR_BANKSEL_EN
    always_ff @(posedge ddrclk or posedge reset) begin
        if (reset)          rdsel <= 2'd0;
        else if (line_done) rdsel <= rdsel + 2'd1;
    end
`endif

endmodule
